instruction_fetch: RTL and testbench

- IF stage plus IF/ID pipeline register of the 5-stage RISC-V pipeline.
- Directly upstream of the decode stage: supplies InstrD and PC values to decode and execute.
- Owns the PC and drives a variable-latency instruction memory with at most one request outstanding.
- Handles the decode stall, decode flush and execute-stage branch/jump redirect, including cancelling an in-flight fetch.

---
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage and IF/ID register: owns PCF and fetches from a variable-latency memory, one request at a time.
// Optional IFID_BUBBLE_NOP_EN: a flush also turns the IF/ID contents into a NOP bubble with zeroed PCs.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state, state_n;
    logic [31:0] pcf, pcf_n;
    logic [31:0] hold_buf, hold_buf_n;
    logic        discard, discard_n;
    logic        outstanding, outstanding_n;
    logic        load;
    logic [31:0] load_word;
    logic        rsp;
    logic [31:0] target;

    // A response only counts when it answers our own outstanding request.
    assign rsp       = imem_rvalid & outstanding;
    assign target    = PCTargetE & ALIGN_MASK;
    assign imem_addr = pcf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pcf         <= RESET_PC;
            hold_buf    <= NOP_INSTR;
            discard     <= 1'b0;
            outstanding <= 1'b0;
        end else begin
            state       <= state_n;
            pcf         <= pcf_n;
            hold_buf    <= hold_buf_n;
            discard     <= discard_n;
            outstanding <= outstanding_n;
        end
    end

    always_comb begin
        state_n       = state;
        pcf_n         = pcf;
        hold_buf_n    = hold_buf;
        discard_n     = discard;
        outstanding_n = outstanding;
        load          = 1'b0;
        load_word     = hold_buf;
        imem_req      = 1'b0;

        case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
                imem_req      = 1'b1;
                outstanding_n = 1'b1;
                state_n       = WAIT;
                if (PCSrcE) begin
                    discard_n = 1'b1;
                end
            end
            WAIT: begin
                if (rsp) begin
                    outstanding_n = 1'b0;
                    if (PCSrcE || discard) begin
                        discard_n = 1'b0;
                        state_n   = REQ;
                    end else if (!StallD) begin
                        load      = 1'b1;
                        load_word = imem_rdata;
                        pcf_n     = pcf + 32'd4;
                        state_n   = REQ;
                    end else begin
                        hold_buf_n = imem_rdata;
                        state_n    = HOLD;
                    end
                end else if (PCSrcE) begin
                    discard_n = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    state_n = REQ;
                end else if (!StallD) begin
                    load    = 1'b1;
                    pcf_n   = pcf + 32'd4;
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A redirect overrides any sequential PC advance decided above.
        if (PCSrcE) begin
            pcf_n = target;
        end
    end

    // ValidD drops after every unstalled cycle without a load, so decode sees each word once.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            ValidD   <= 1'b0;
`ifdef IFID_BUBBLE_NOP_EN
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
`endif
        end else if (!StallD) begin
            ValidD <= load;
            if (load) begin
                InstrD   <= load_word;
                PCD      <= pcf;
                PCPlus4D <= pcf + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run checked
// against an architectural model of the instruction stream decode should accept.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 0;
    int          mem_lat_cfg = 1;
    bit          rand_lat = 0;
    bit          force_rvalid = 0;
    logic [31:0] force_rdata = 32'h0;
    logic [31:0] paddr = 32'h0;

    instruction_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    // Advance one cycle and act as the instruction memory for the new cycle.
    task tick();
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (lat > 0) begin
            lat--;
            if (lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(paddr);
            end
        end
        if (force_rvalid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = force_rdata;
        end
        if (imem_req === 1'b1) begin
            checks++;
            if (lat != 0 || imem_addr[1:0] !== 2'b00) begin
                errors++;
                $display("[TB] FAIL imem_protocol: addr=%h pending=%0d, required aligned addr and none pending",
                         imem_addr, lat);
            end
            lat   = rand_lat ? int'($urandom_range(1, 4)) : mem_lat_cfg;
            paddr = imem_addr;
        end
    endtask

    task automatic wait_new_req(input string name);
        int n;
        n = 0;
        tick();
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no imem_req, required one within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req: got %b, required 0", imem_req);
        end
        checks++;
        if (InstrD !== 32'h0000_0013) begin
            errors++;
            $display("[TB] FAIL reset_instr: got %h, required 00000013", InstrD);
        end
        checks++;
        if (PCD !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_pcd: got %h, required 0", PCD);
        end
        checks++;
        if (PCPlus4D !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_pcplus4: got %h, required 0", PCPlus4D);
        end
        checks++;
        if (ValidD !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b, required 0", ValidD);
        end
        rst = 1'b0;
        lat = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        logic [31:0] exp_pcd;
        int          last;
        int          nreq;
        int          nval;
        exp_addr    = 32'h0;
        exp_pcd     = 32'h0;
        last        = -1;
        nreq        = 0;
        nval        = 0;
        mem_lat_cfg = 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (imem_req === 1'b1) begin
                checks++;
                if (imem_addr !== exp_addr) begin
                    errors++;
                    $display("[TB] FAIL seq_addr: got %h, required %h", imem_addr, exp_addr);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("[TB] FAIL seq_req_spacing: got %0d cycles, required 2", cyc - last);
                    end
                end
                last = cyc;
                exp_addr += 32'd4;
                nreq++;
            end
            if (ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pcd || InstrD !== word(exp_pcd) || PCPlus4D !== exp_pcd + 32'd4) begin
                    errors++;
                    $display("[TB] FAIL seq_ifid: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                             PCD, InstrD, PCPlus4D, exp_pcd, word(exp_pcd), exp_pcd + 32'd4);
                end
                exp_pcd += 32'd4;
                nval++;
            end
        end
        checks++;
        if (nreq != 7 || nval != 6) begin
            errors++;
            $display("[TB] FAIL seq_counts: got req=%0d valid=%0d, required req=7 valid=6", nreq, nval);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] held_pcd;
        logic [31:0] held_instr;
        mem_lat_cfg = 1;
        wait_new_req("stall");
        a          = imem_addr;
        held_pcd   = PCD;
        held_instr = InstrD;
        StallD     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_no_req: got %b at stall cycle %0d, required 0", imem_req, k);
            end
            checks++;
            if (PCD !== held_pcd || InstrD !== held_instr) begin
                errors++;
                $display("[TB] FAIL stall_hold: got pc=%h instr=%h, required pc=%h instr=%h",
                         PCD, InstrD, held_pcd, held_instr);
            end
        end
        StallD = 1'b0;
        tick();
        checks++;
        if (ValidD !== 1'b1 || PCD !== a || InstrD !== word(a) || PCPlus4D !== a + 32'd4) begin
            errors++;
            $display("[TB] FAIL stall_release: got v=%b pc=%h instr=%h pc4=%h, required v=1 pc=%h instr=%h pc4=%h",
                     ValidD, PCD, InstrD, PCPlus4D, a, word(a), a + 32'd4);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a + 32'd4) begin
            errors++;
            $display("[TB] FAIL stall_next_req: got req=%b addr=%h, required req=1 addr=%h",
                     imem_req, imem_addr, a + 32'd4);
        end
    endtask

    task automatic test_redirect();
        bit seen_req;
        bit seen_val;
        seen_req    = 0;
        seen_val    = 0;
        mem_lat_cfg = 3;
        wait_new_req("redirect");
        tick();
        PCSrcE    = 1'b1;
        FlushD    = 1'b1;
        PCTargetE = 32'h0000_0103;
        tick();
        PCSrcE    = 1'b0;
        FlushD    = 1'b0;
        PCTargetE = 32'h0;
        checks++;
        if (ValidD !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redirect_flush: got valid=%b, required 0", ValidD);
        end
        tick();
        mem_lat_cfg = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req === 1'b1 && !seen_req) begin
                seen_req = 1;
                checks++;
                if (imem_addr !== 32'h0000_0100) begin
                    errors++;
                    $display("[TB] FAIL redirect_addr: got %h, required 00000100", imem_addr);
                end
            end
            if (ValidD === 1'b1 && !seen_val) begin
                seen_val = 1;
                checks++;
                if (PCD !== 32'h0000_0100 || InstrD !== word(32'h0000_0100)) begin
                    errors++;
                    $display("[TB] FAIL redirect_first_valid: got pc=%h instr=%h, required pc=00000100 instr=%h",
                             PCD, InstrD, word(32'h0000_0100));
                end
            end
        end
        checks++;
        if (!seen_req || !seen_val) begin
            errors++;
            $display("[TB] FAIL redirect_progress: got req=%b valid=%b, required both", seen_req, seen_val);
        end
    endtask

    task automatic test_flush_rvalid();
        logic [31:0] old_instr;
        logic [31:0] old_pcd;
        logic [31:0] old_p4;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcd;
        logic [31:0] exp_p4;
        bit          seen_val;
        seen_val    = 0;
        mem_lat_cfg = 2;
        wait_new_req("flush_rvalid");
        mem_lat_cfg = 1;
        tick();
        tick();
        old_instr = InstrD;
        old_pcd   = PCD;
        old_p4    = PCPlus4D;
`ifdef IFID_BUBBLE_NOP_EN
        exp_instr = 32'h0000_0013;
        exp_pcd   = 32'h0;
        exp_p4    = 32'h0;
`else
        exp_instr = old_instr;
        exp_pcd   = old_pcd;
        exp_p4    = old_p4;
`endif
        checks++;
        if (imem_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_rvalid_align: got rvalid=%b, required 1", imem_rvalid);
        end
        PCSrcE    = 1'b1;
        FlushD    = 1'b1;
        PCTargetE = 32'h0000_2042;
        tick();
        PCSrcE    = 1'b0;
        FlushD    = 1'b0;
        PCTargetE = 32'h0;
        checks++;
        if (ValidD !== 1'b0 || InstrD !== exp_instr || PCD !== exp_pcd || PCPlus4D !== exp_p4) begin
            errors++;
            $display("[TB] FAIL flush_rvalid_ifid: got v=%b instr=%h pc=%h pc4=%h, required v=0 instr=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, exp_instr, exp_pcd, exp_p4);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2040) begin
            errors++;
            $display("[TB] FAIL flush_rvalid_req: got req=%b addr=%h, required req=1 addr=00002040",
                     imem_req, imem_addr);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ValidD === 1'b1 && !seen_val) begin
                seen_val = 1;
                checks++;
                if (PCD !== 32'h0000_2040 || InstrD !== word(32'h0000_2040)) begin
                    errors++;
                    $display("[TB] FAIL flush_rvalid_first_valid: got pc=%h instr=%h, required pc=00002040 instr=%h",
                             PCD, InstrD, word(32'h0000_2040));
                end
            end
        end
        checks++;
        if (!seen_val) begin
            errors++;
            $display("[TB] FAIL flush_rvalid_progress: got no valid instruction, required one");
        end
    endtask

    task automatic test_reset_wait();
        mem_lat_cfg = 3;
        wait_new_req("reset_wait");
        tick();
        rst          = 1'b1;
        force_rvalid = 1'b1;
        force_rdata  = 32'hBAD0_0001;
        tick();
        rst          = 1'b0;
        force_rvalid = 1'b0;
        mem_lat_cfg  = 1;
        checks++;
        if (ValidD !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wait_idle: got v=%b req=%b, required v=0 req=0", ValidD, imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ValidD !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wait_first_req: got req=%b addr=%h v=%b, required req=1 addr=0 v=0",
                     imem_req, imem_addr, ValidD);
        end
        tick();
        checks++;
        if (ValidD !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wait_stale: got v=%b, required 0", ValidD);
        end
        tick();
        checks++;
        if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== word(32'h0)) begin
            errors++;
            $display("[TB] FAIL reset_wait_real: got v=%b pc=%h instr=%h, required v=1 pc=0 instr=%h",
                     ValidD, PCD, InstrD, word(32'h0));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [2];
        logic [31:0] exp_pcd [2];
        int          nreq;
        int          nval;
        exp_addr[0] = 32'hFFFF_FFFC;
        exp_addr[1] = 32'h0;
        exp_pcd[0]  = 32'hFFFF_FFFC;
        exp_pcd[1]  = 32'h0;
        nreq        = 0;
        nval        = 0;
        mem_lat_cfg = 1;
        PCSrcE      = 1'b1;
        FlushD      = 1'b1;
        PCTargetE   = 32'hFFFF_FFFF;
        tick();
        PCSrcE    = 1'b0;
        FlushD    = 1'b0;
        PCTargetE = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (imem_req === 1'b1 && nreq < 2) begin
                checks++;
                if (imem_addr !== exp_addr[nreq]) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr%0d: got %h, required %h", nreq, imem_addr, exp_addr[nreq]);
                end
                nreq++;
            end
            if (ValidD === 1'b1 && nval < 2) begin
                checks++;
                if (PCD !== exp_pcd[nval] || PCPlus4D !== exp_pcd[nval] + 32'd4 ||
                    InstrD !== word(exp_pcd[nval])) begin
                    errors++;
                    $display("[TB] FAIL wrap_ifid%0d: got pc=%h pc4=%h instr=%h, required pc=%h pc4=%h instr=%h",
                             nval, PCD, PCPlus4D, InstrD, exp_pcd[nval], exp_pcd[nval] + 32'd4,
                             word(exp_pcd[nval]));
                end
                nval++;
            end
        end
        checks++;
        if (nreq != 2 || nval != 2) begin
            errors++;
            $display("[TB] FAIL wrap_progress: got req=%0d valid=%0d, required 2 and 2", nreq, nval);
        end
    endtask

    // Decode must accept exactly the program-order stream: sequential from the last redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          consumed;
        bit          redir;
        rst = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        lat      = 0;
        rand_lat = 1;
        exp_pc   = 32'h0;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            StallD    = ($urandom_range(0, 99) < 30);
            redir     = ($urandom_range(0, 99) < 4);
            PCSrcE    = redir;
            FlushD    = redir;
            PCTargetE = 32'h0;
            if (redir) begin
                PCTargetE = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            end
            if (ValidD === 1'b1 && !StallD && !FlushD) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== word(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
                    errors++;
                    $display("[TB] FAIL random_stream: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                             PCD, InstrD, PCPlus4D, exp_pc, word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc += 32'd4;
                consumed++;
            end
            if (redir) begin
                exp_pc = PCTargetE & 32'hFFFF_FFFC;
            end
            tick();
        end
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        rand_lat  = 0;
        checks++;
        if (consumed < 100) begin
            errors++;
            $display("[TB] FAIL random_progress: got %0d instructions, required at least 100", consumed);
        end
    endtask

    initial begin
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        PCSrcE      = 1'b0;
        PCTargetE   = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush_rvalid();
        test_reset_wait();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
